// File: rtl/sram_march_bist.sv
// March C- self-test engine for a single-port SRAM; optional first-fail log built when SRAM_BIST_FAILLOG_EN is defined.
// Latency: N*(1 + 4*(2+READ_LAT) + (1+READ_LAT)) cycles from first write to done; a mismatch ends the run the next cycle.
// Backpressure: none; start is a one-cycle request honoured only in IDLE, ignored while busy or in the DONE cycle.
module sram_march_bist #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 9,
    parameter int MASK_W   = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_obs,
    output logic              csb0,
    output logic              web0,
    output logic [MASK_W-1:0] wmask0,
    output logic              spare_wen0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0
);

    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [1:0]        LAT_LAST = 2'(READ_LAT - 1);

    state_t            state, state_nx;
    logic [2:0]        elem, elem_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [1:0]        lat_cnt, lat_nx;
    logic              busy_nx, done_nx, pass_nx;

    logic              elem_down, elem_last, rd_ok;
    logic [2:0]        elem_adv;
    logic [ADDR_W-1:0] addr_adv;
    logic [DATA_W-1:0] wr_bg, rd_bg;

    // E3/E4 walk downwards; backgrounds alternate D0/D1 per element
    assign elem_down = (elem == 3'd3) || (elem == 3'd4);
    assign elem_last = elem_down ? (addr == '0) : (addr == ADDR_MAX);
    assign elem_adv  = elem + 3'd1;
    assign wr_bg     = {DATA_W{(elem == 3'd1) || (elem == 3'd3)}};
    assign rd_bg     = {DATA_W{(elem == 3'd2) || (elem == 3'd4)}};
    assign rd_ok     = (dout0 == rd_bg);

    // On wrap, the next element starts at the top when it is a down element
    assign addr_adv = elem_last ? (((elem_adv == 3'd3) || (elem_adv == 3'd4)) ? ADDR_MAX : '0)
                                : (elem_down ? addr - ADDR_ONE : addr + ADDR_ONE);

    always_comb begin
        state_nx = state;
        elem_nx  = elem;
        addr_nx  = addr;
        lat_nx   = lat_cnt;
        busy_nx  = busy;
        done_nx  = done;
        pass_nx  = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WR;
                    elem_nx  = 3'd0;
                    addr_nx  = '0;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                end
            end
            WR: begin
                addr_nx = addr_adv;
                if (elem_last) elem_nx = elem_adv;
                state_nx = ((elem == 3'd0) && !elem_last) ? WR : RD;
            end
            RD: begin
                state_nx = RWAIT;
                lat_nx   = 2'd0;
            end
            RWAIT: begin
                if (lat_cnt != LAT_LAST) begin
                    lat_nx = lat_cnt + 2'd1;
                end else if (!rd_ok) begin
                    state_nx = DONE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    pass_nx  = 1'b0;
                end else if (elem != 3'd5) begin
                    state_nx = WR;
                end else if (elem_last) begin
                    state_nx = DONE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    pass_nx  = 1'b1;
                end else begin
                    addr_nx  = addr_adv;
                    state_nx = RD;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            elem    <= 3'd0;
            addr    <= '0;
            lat_cnt <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state   <= state_nx;
            elem    <= elem_nx;
            addr    <= addr_nx;
            lat_cnt <= lat_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            pass    <= pass_nx;
        end
    end

    assign csb0       = !((state == WR) || (state == RD));
    assign web0       = (state != WR);
    assign addr0      = addr;
    assign din0       = wr_bg;
    assign wmask0     = '1;
    assign spare_wen0 = 1'b0;

`ifdef SRAM_BIST_FAILLOG_EN
    logic cap_en, clr_fail;
    assign cap_en   = (state == RWAIT) && (lat_cnt == LAT_LAST) && !rd_ok;
    assign clr_fail = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_obs  <= '0;
        end else if (clr_fail) begin
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_obs  <= '0;
        end else if (cap_en) begin
            fail_addr <= addr;
            fail_exp  <= rd_bg;
            fail_obs  <= dout0;
        end
    end
`else
    assign fail_addr = '0;
    assign fail_exp  = '0;
    assign fail_obs  = '0;
`endif

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two instances (READ_LAT 1 and 2) against behavioural SRAMs with injectable stuck-at faults.
// Expected run length, op order and fail log come from a march-level reference model.
module tb_sram_march_bist;

    localparam int AW = 5;
    localparam int DW = 9;
    localparam int MW = 4;
    localparam int N  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start2 = 1'b0;
    always #5 clk = ~clk;

    logic          busy1, done1, pass1, csb1, web1, sp1;
    logic [AW-1:0] fa1, addr1;
    logic [DW-1:0] fe1, fo1, din1, dout1;
    logic [MW-1:0] wm1;
    logic          busy2, done2, pass2, csb2, web2, sp2;
    logic [AW-1:0] fa2, addr2;
    logic [DW-1:0] fe2, fo2, din2, dout2;
    logic [MW-1:0] wm2;

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fa1), .fail_exp(fe1), .fail_obs(fo1), .csb0(csb1), .web0(web1),
        .wmask0(wm1), .spare_wen0(sp1), .addr0(addr1), .din0(din1), .dout0(dout1));

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(fa2), .fail_exp(fe2), .fail_obs(fo2), .csb0(csb2), .web0(web2),
        .wmask0(wm2), .spare_wen0(sp2), .addr0(addr2), .din0(din2), .dout0(dout2));

    // fault injection shared by both SRAM models and the reference model
    logic          fault_on = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_sa1 = '0, f_sa0 = '0;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input logic [AW-1:0] a);
        if (fault_on && a == f_addr) return (v | f_sa1) & ~f_sa0;
        return v;
    endfunction

    // SRAM models: data valid only for the one cycle READ_LAT edges after issue, random junk otherwise
    logic [DW-1:0]        mem1 [N];
    logic [DW-1:0]        mem2 [N];
    logic                 pv1;
    logic [DW-1:0]        pd1, garb1, garb2;
    logic [1:0]           pv2;
    logic [1:0][DW-1:0]   pd2;

    always @(posedge clk) begin
        if (!csb1 && !web1) mem1[addr1] <= din1;
        if (!csb2 && !web2) mem2[addr2] <= din2;
        pv1   <= !csb1 && web1;
        pd1   <= faulty(mem1[addr1], addr1);
        pv2   <= {pv2[0], !csb2 && web2};
        pd2   <= {pd2[0], faulty(mem2[addr2], addr2)};
        garb1 <= DW'($urandom);
        garb2 <= DW'($urandom);
    end
    assign dout1 = pv1    ? pd1    : garb1;
    assign dout2 = pv2[1] ? pd2[1] : garb2;

    logic sel = 1'b0;
    wire          s_busy = sel ? busy2 : busy1;
    wire          s_done = sel ? done2 : done1;
    wire          s_pass = sel ? pass2 : pass1;
    wire          s_csb  = sel ? csb2  : csb1;
    wire          s_web  = sel ? web2  : web1;
    wire          s_sp   = sel ? sp2   : sp1;
    wire [AW-1:0] s_fa   = sel ? fa2   : fa1;
    wire [AW-1:0] s_addr = sel ? addr2 : addr1;
    wire [DW-1:0] s_fe   = sel ? fe2   : fe1;
    wire [DW-1:0] s_fo   = sel ? fo2   : fo1;
    wire [DW-1:0] s_din  = sel ? din2  : din1;
    wire [MW-1:0] s_wm   = sel ? wm2   : wm1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [14:0]   got_ops [$];
    logic [14:0]   exp_ops [$];
    int            bcnt, exp_cyc;
    logic          exp_pass;
    logic [AW-1:0] exp_fa;
    logic [DW-1:0] exp_fe, exp_fo;

    // reference: walk the March C- element table with a plain array memory
    task automatic model(input int rl);
        logic [DW-1:0] m [N];
        int            down [6] = '{0, 0, 0, 1, 1, 0};
        int            rd   [6] = '{0, 1, 1, 1, 1, 1};
        int            rv   [6] = '{0, 0, 1, 0, 1, 0};
        int            wv   [6] = '{0, 1, 0, 1, 0, 0};
        logic [AW-1:0] a;
        logic [DW-1:0] want, got;
        exp_ops.delete();
        exp_cyc = 0; exp_pass = 1'b1; exp_fa = '0; exp_fe = '0; exp_fo = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = AW'(down[e] != 0 ? N - 1 - k : k);
                if (rd[e] != 0) begin
                    want = (rv[e] != 0) ? '1 : '0;
                    got  = faulty(m[a], a);
                    exp_ops.push_back({1'b1, a, {DW{1'b0}}});
                    exp_cyc += 1 + rl;
                    if (got != want) begin
                        exp_pass = 1'b0;
`ifdef SRAM_BIST_FAILLOG_EN
                        exp_fa = a; exp_fe = want; exp_fo = got;
`endif
                        return;
                    end
                end
                if (e != 5) begin
                    m[a] = (wv[e] != 0) ? '1 : '0;
                    exp_ops.push_back({1'b0, a, m[a]});
                    exp_cyc += 1;
                end
            end
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start2 = v; else start1 = v;
    endtask

    task automatic run_test(input string tag, input int x1, input int x2, input int rst_at,
                            input bit pulse_in_done);
        bit fin = 0;
        got_ops.delete();
        bcnt = 0;
        @(negedge clk); drive_start(1'b1);
        @(negedge clk); drive_start(1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (s_busy) bcnt++;
            if (!s_csb) got_ops.push_back({s_web, s_addr, s_web ? {DW{1'b0}} : s_din});
            if (s_done && !s_busy) begin fin = 1; break; end
            if (cyc == rst_at) begin rst_n = 1'b0; fin = 1; break; end
            drive_start(cyc == x1 || cyc == x2);
            @(negedge clk);
        end
        drive_start(1'b0);
        if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
        if (fin && pulse_in_done) begin
            drive_start(1'b1);
            @(negedge clk);
            drive_start(1'b0);
        end
    endtask

    task automatic verify(input string tag, input int rl);
        model(rl);
        chk({tag, "_cycles"}, bcnt, exp_cyc);
        chk({tag, "_done"}, s_done, 1'b1);
        chk({tag, "_pass"}, s_pass, exp_pass);
        chk({tag, "_fail_addr"}, s_fa, exp_fa);
        chk({tag, "_fail_exp"}, s_fe, exp_fe);
        chk({tag, "_fail_obs"}, s_fo, exp_fo);
        chk({tag, "_nops"}, got_ops.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++) begin
            chk($sformatf("%s_op%0d", tag, i), got_ops[i], exp_ops[i]);
            if (got_ops[i] !== exp_ops[i]) break;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_hold"}, {s_done, s_pass, s_busy, s_csb}, {1'b1, exp_pass, 1'b0, 1'b1});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_flags"}, {s_busy, s_done, s_pass}, 3'b000);
        chk({tag, "_fail"}, {s_fa, s_fe, s_fo}, '0);
        chk({tag, "_csb_web"}, {s_csb, s_web}, 2'b11);
        chk({tag, "_wmask"}, s_wm, {MW{1'b1}});
        chk({tag, "_addr_din_spare"}, {s_addr, s_din, s_sp}, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit csb_low, busy_seen;
        int bitn;
        repeat (3) @(negedge clk);
        sel = 1'b0; check_reset("rst_lat1");
        sel = 1'b1; check_reset("rst_lat2");
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0; fault_on = 1'b0;
        run_test("clean1", -1, -1, -1, 0);
        chk("clean1_480", bcnt, 480);
        verify("clean1", 1);

        fault_on = 1'b1; f_addr = 5'd7; f_sa1 = 9'h008; f_sa0 = 9'h000;
        run_test("sa1_b3_a7", -1, -1, -1, 0);
        chk("sa1_b3_a7_len", bcnt, 55);
`ifdef SRAM_BIST_FAILLOG_EN
        chk("sa1_b3_a7_log", {s_fa, s_fe, s_fo}, {5'd7, 9'h000, 9'h008});
`endif
        verify("sa1_b3_a7", 1);

        f_addr = 5'd31; f_sa1 = 9'h000; f_sa0 = 9'h100;
        run_test("sa0_b8_a31", -1, -1, -1, 0);
`ifdef SRAM_BIST_FAILLOG_EN
        chk("sa0_b8_a31_log", {s_fa, s_fe, s_fo}, {5'd31, 9'h1FF, 9'h0FF});
`endif
        verify("sa0_b8_a31", 1);

        sel = 1'b1; fault_on = 1'b0;
        run_test("clean2", -1, -1, -1, 0);
        chk("clean2_640", bcnt, 640);
        verify("clean2", 2);

        sel = 1'b0;
        run_test("ignore_start", 10, 200, -1, 1);
        verify("ignore_start", 1);

        run_test("midrst", -1, -1, 100, 0);
        #1;
        chk("midrst_now", {s_busy, s_done, s_csb, s_web, s_addr}, {1'b0, 1'b0, 1'b1, 1'b1, 5'd0});
        csb_low = 0; busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (!s_csb) csb_low = 1;
            if (s_busy) busy_seen = 1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!s_csb) csb_low = 1;
            if (s_busy) busy_seen = 1;
        end
        chk("midrst_quiet", {csb_low, busy_seen}, 2'b00);
        run_test("after_rst", -1, -1, -1, 0);
        chk("after_rst_480", bcnt, 480);
        verify("after_rst", 1);

        for (int r = 0; r < 8; r++) begin
            sel      = 1'($urandom_range(0, 1));
            fault_on = ($urandom_range(0, 3) != 0);
            f_addr   = AW'($urandom_range(0, N - 1));
            bitn     = $urandom_range(0, DW - 1);
            f_sa1    = '0;
            f_sa0    = '0;
            if ($urandom_range(0, 1) != 0) f_sa1[bitn] = 1'b1;
            else                           f_sa0[bitn] = 1'b1;
            run_test($sformatf("rnd%0d", r), -1, -1, -1, 0);
            verify($sformatf("rnd%0d", r), sel ? 2 : 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
